// File: rtl/wb_sram_port_if.sv
// rtl/wb_sram_port_if.sv - Wishbone classic slave bus bundle for the SRAM port
interface wb_sram_port_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i,
        input  wbs_stb_i,
        input  wbs_we_i,
        input  wbs_sel_i,
        input  wbs_adr_i,
        input  wbs_dat_i,
        output wbs_ack_o,
        output wbs_dat_o
    );

    modport master (
        output wbs_cyc_i,
        output wbs_stb_i,
        output wbs_we_i,
        output wbs_sel_i,
        output wbs_adr_i,
        output wbs_dat_i,
        input  wbs_ack_o,
        input  wbs_dat_o
    );
endinterface

// File: rtl/wb_sram_port.sv
// rtl/wb_sram_port.sv - Wishbone classic slave bridging a single-port SRAM macro
// One SRAM access per bus request; misses are acked without touching the SRAM.
module wb_sram_port #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          ADDR_WIDTH   = 8,
    parameter int          READ_LATENCY = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_sram_port_if.slave         wbs,
    output logic                  csb0,
    output logic                  web0,
    output logic [3:0]            wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [31:0]           din0,
    input  logic [31:0]           dout0,
    output logic [31:0]           status_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_we;
    logic [1:0]            r_wait_cnt;
    logic                  r_csb0;
    logic                  r_web0;
    logic [3:0]            r_wmask0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [31:0]           r_din0;
    logic [31:0]           r_dat_o;
    logic [15:0]           r_wr_count;
    logic [15:0]           r_rd_count;

    logic                  w_req;
    logic                  w_hit;
    logic                  w_accept;
    logic                  w_load_rd;
    logic                  w_miss_rd;
    logic                  w_inc_wr;
    logic [1:0]            w_unused_adr;

    assign w_req        = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign w_hit        = (wbs.wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign w_accept     = (r_state == IDLE) && w_req;
    assign w_unused_adr = wbs.wbs_adr_i[1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_nxt = w_hit ? ISSUE : ACK;
                end
            end
            ISSUE: begin
                // The SRAM already saw csb0 low this cycle, so dropping cyc only skips the ack.
                if (!wbs.wbs_cyc_i) begin
                    w_state_nxt = IDLE;
                end else if (r_we) begin
                    w_state_nxt = ACK;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!wbs.wbs_cyc_i) begin
                    w_state_nxt = IDLE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_load_rd = (r_state == WAIT)  && (w_state_nxt == ACK);
    assign w_inc_wr  = (r_state == ISSUE) && (w_state_nxt == ACK);
    assign w_miss_rd = w_accept && !w_hit && !wbs.wbs_we_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_wait_cnt <= 2'd0;
            r_csb0     <= 1'b1;
            r_web0     <= 1'b1;
            r_wmask0   <= 4'd0;
            r_addr0    <= '0;
            r_din0     <= 32'd0;
            r_dat_o    <= 32'd0;
            r_wr_count <= 16'd0;
            r_rd_count <= 16'd0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_we <= wbs.wbs_we_i;
            end

            // Address/data/mask only move on a hit so they hold through misses.
            if (w_accept && w_hit) begin
                r_addr0  <= wbs.wbs_adr_i[ADDR_WIDTH+1:2];
                r_din0   <= wbs.wbs_dat_i;
                r_wmask0 <= wbs.wbs_sel_i;
            end

            r_csb0 <= (w_state_nxt != ISSUE);
            r_web0 <= (w_state_nxt == ISSUE) ? ~wbs.wbs_we_i : 1'b1;

            if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + 2'd1;
            end else begin
                r_wait_cnt <= 2'd0;
            end

            if (w_load_rd) begin
                r_dat_o <= dout0;
            end else if (w_miss_rd) begin
                r_dat_o <= 32'd0;
            end

            if (w_inc_wr) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_load_rd) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
        end
    end

    assign wbs.wbs_ack_o = (r_state == ACK);
    assign wbs.wbs_dat_o = r_dat_o;
    assign csb0          = r_csb0;
    assign web0          = r_web0;
    assign wmask0        = r_wmask0;
    assign addr0         = r_addr0;
    assign din0          = r_din0;
    assign status_o      = {r_wr_count, r_rd_count};

endmodule

// File: tb/tb_wb_sram_port.sv
// tb/tb_wb_sram_port.sv - directed table, corner sequences and random traffic against a reference model
module tb_wb_sram_port;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          AW   = 8;
    localparam int          RL   = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_clr = 1'b1;
    logic          csb0, web0;
    logic [3:0]    wmask0;
    logic [AW-1:0] addr0;
    logic [31:0]   din0, dout0, status_o;

    wb_sram_port_if bus();

    wb_sram_port #(
        .BASE_ADDR   (BASE),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wbs     (bus),
        .csb0    (csb0),
        .web0    (web0),
        .wmask0  (wmask0),
        .addr0   (addr0),
        .din0    (din0),
        .dout0   (dout0),
        .status_o(status_o)
    );

    always #5 clk = ~clk;

    logic [31:0] sram [0:(1<<AW)-1];
    logic [31:0] q1, q2;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) sram[i] <= 32'd0;
        end else if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) sram[addr0][8*b +: 8] <= din0[8*b +: 8];
            end else begin
                q1 <= sram[addr0];
            end
        end
        q2 <= q1;
    end
    assign dout0 = (RL == 1) ? q1 : q2;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [0:(1<<AW)-1];
    logic [15:0] m_wr = 16'd0;
    logic [15:0] m_rd = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic is_hit(input logic [31:0] adr);
        logic [31:0] b;
        b = BASE;
        return (adr >> (AW + 2)) == (b >> (AW + 2));
    endfunction

    task automatic model_apply(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, output int lat, output logic [31:0] rdat);
        int idx;
        idx  = int'((adr - BASE) / 4) % (1 << AW);
        rdat = 32'd0;
        if (!is_hit(adr)) begin
            lat = 1;
        end else if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b])
                    ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8*b))) | (dat & (32'hFF << (8*b)));
            m_wr = m_wr + 16'd1;
            lat  = 2;
        end else begin
            rdat = ref_mem[idx];
            m_rd = m_rd + 16'd1;
            lat  = 2 + RL;
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        output int lat, output int ncsb, output logic [31:0] rdat, output logic [3:0] c_wmask,
                        output logic [AW-1:0] c_addr, output logic c_web, output logic [31:0] c_din,
                        output logic ack_after);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
        lat = 0; ncsb = 0; rdat = 32'd0; c_wmask = 4'd0; c_addr = '0; c_web = 1'b1; c_din = 32'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!csb0) begin
                ncsb++; c_wmask = wmask0; c_addr = addr0; c_web = web0; c_din = din0;
            end
            if (bus.wbs_ack_o) begin
                lat = i + 1; rdat = bus.wbs_dat_o;
                break;
            end
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        ack_after = bus.wbs_ack_o;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          lat;
        int          ncsb;
        logic [31:0] rdat;
        logic [31:0] status;
        logic [3:0]  wmask;
        logic [7:0]  addr;
    } vec_t;

    initial begin
        vec_t        vt [12];
        int          lat, ncsb, elat;
        logic [31:0] rdat, erdat, c_din;
        logic [3:0]  c_wmask;
        logic [AW-1:0] c_addr;
        logic        c_web, ack_after;

        vt[0]  = '{1'b1, 32'h3000_0010, 32'hA5A5_1234, 4'hF, 2, 1, 32'h0,          32'h0001_0000, 4'hF, 8'h04};
        vt[1]  = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 3, 1, 32'hA5A5_1234, 32'h0001_0001, 4'hF, 8'h04};
        vt[2]  = '{1'b1, 32'h3000_0020, 32'h0,         4'hF, 2, 1, 32'h0,          32'h0002_0001, 4'hF, 8'h08};
        vt[3]  = '{1'b1, 32'h3000_0020, 32'hFFFF_FFFF, 4'h4, 2, 1, 32'h0,          32'h0003_0001, 4'h4, 8'h08};
        vt[4]  = '{1'b0, 32'h3000_0020, 32'h0,         4'hF, 3, 1, 32'h00FF_0000, 32'h0003_0002, 4'hF, 8'h08};
        vt[5]  = '{1'b0, 32'h3000_0400, 32'h0,         4'hF, 1, 0, 32'h0,          32'h0003_0002, 4'h0, 8'h00};
        vt[6]  = '{1'b1, 32'h3000_0000, 32'h1234_5678, 4'h0, 2, 1, 32'h0,          32'h0004_0002, 4'h0, 8'h00};
        vt[7]  = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 3, 1, 32'h0,          32'h0004_0003, 4'hF, 8'h00};
        vt[8]  = '{1'b1, 32'h4000_0000, 32'h5555_5555, 4'hF, 1, 0, 32'h0,          32'h0004_0003, 4'h0, 8'h00};
        vt[9]  = '{1'b1, 32'h3000_03FC, 32'hDEAD_BEEF, 4'hF, 2, 1, 32'h0,          32'h0005_0003, 4'hF, 8'hFF};
        vt[10] = '{1'b0, 32'h3000_03FF, 32'h0,         4'hF, 3, 1, 32'hDEAD_BEEF, 32'h0005_0004, 4'hF, 8'hFF};
        vt[11] = '{1'b0, 32'h2FFF_FFFC, 32'h0,         4'hF, 1, 0, 32'h0,          32'h0005_0004, 4'h0, 8'h00};

        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'd0;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'd0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        chk("rst_dat", bus.wbs_dat_o, 32'd0);
        chk("rst_csb", {31'd0, csb0}, 32'd1);
        chk("rst_web", {31'd0, web0}, 32'd1);
        chk("rst_wmask", {28'd0, wmask0}, 32'd0);
        chk("rst_addr", {24'd0, addr0}, 32'd0);
        chk("rst_din", din0, 32'd0);
        chk("rst_status", status_o, 32'd0);
        @(negedge clk);
        mem_clr = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            xact(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, lat, ncsb, rdat, c_wmask, c_addr, c_web, c_din, ack_after);
            model_apply(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, elat, erdat);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_csb_cycles", i), ncsb, vt[i].ncsb);
            chk($sformatf("vec%0d_ack_once", i), {31'd0, ack_after}, 32'd0);
            chk($sformatf("vec%0d_status", i), status_o, vt[i].status);
            if (!vt[i].we) chk($sformatf("vec%0d_rdat", i), rdat, vt[i].rdat);
            if (vt[i].ncsb != 0) begin
                chk($sformatf("vec%0d_wmask", i), {28'd0, c_wmask}, {28'd0, vt[i].wmask});
                chk($sformatf("vec%0d_addr", i), {24'd0, c_addr}, {24'd0, vt[i].addr});
                chk($sformatf("vec%0d_web", i), {31'd0, c_web}, {31'd0, ~vt[i].we});
            end
        end

        // back-to-back writes: second request held through the first ack
        begin
            int t1, t2;
            t1 = 0; t2 = 0;
            @(negedge clk);
            bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1; bus.wbs_sel_i = 4'hF;
            bus.wbs_adr_i = 32'h3000_0040; bus.wbs_dat_i = 32'h1111_1111;
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk); #1;
                if (bus.wbs_ack_o) begin
                    if (t1 == 0) begin
                        t1 = i;
                        bus.wbs_adr_i = 32'h3000_0044; bus.wbs_dat_i = 32'h2222_2222;
                    end else begin
                        t2 = i;
                        break;
                    end
                end
            end
            bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
            @(posedge clk); #1;
            model_apply(1'b1, 32'h3000_0040, 32'h1111_1111, 4'hF, elat, erdat);
            model_apply(1'b1, 32'h3000_0044, 32'h2222_2222, 4'hF, elat, erdat);
            chk("b2b_first_ack", t1, 2);
            chk("b2b_ack_gap", t2 - t1, 3);
            chk("b2b_status", status_o, {m_wr, m_rd});
            xact(1'b0, 32'h3000_0044, 32'h0, 4'hF, lat, ncsb, rdat, c_wmask, c_addr, c_web, c_din, ack_after);
            model_apply(1'b0, 32'h3000_0044, 32'h0, 4'hF, elat, erdat);
            chk("b2b_readback", rdat, erdat);
        end

        // read aborted in WAIT
        begin
            int nack;
            nack = 0;
            @(negedge clk);
            bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
            bus.wbs_adr_i = 32'h3000_0040; bus.wbs_sel_i = 4'hF;
            @(posedge clk); #1;
            @(posedge clk); #1;
            bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                if (bus.wbs_ack_o) nack++;
            end
            chk("abort_no_ack", nack, 0);
            chk("abort_status", status_o, {m_wr, m_rd});
        end

        // reset asserted in WAIT
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = 32'h3000_0010; bus.wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstwait_csb", {31'd0, csb0}, 32'd1);
        chk("rstwait_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        chk("rstwait_status", status_o, 32'd0);
        chk("rstwait_dat", bus.wbs_dat_o, 32'd0);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        m_wr = 16'd0; m_rd = 16'd0;
        @(posedge clk); #2;
        rst = 1'b0;
        xact(1'b1, 32'h3000_0080, 32'hCAFE_F00D, 4'hF, lat, ncsb, rdat, c_wmask, c_addr, c_web, c_din, ack_after);
        model_apply(1'b1, 32'h3000_0080, 32'hCAFE_F00D, 4'hF, elat, erdat);
        chk("post_rst_lat", lat, 2);
        chk("post_rst_status", status_o, 32'h0001_0000);

        // rd_count wrap
        @(negedge clk);
        force dut.r_rd_count = 16'hFFFF;
        #1;
        release dut.r_rd_count;
        m_rd = 16'hFFFF;
        chk("preload_status", status_o, {m_wr, m_rd});
        xact(1'b0, 32'h3000_0080, 32'h0, 4'hF, lat, ncsb, rdat, c_wmask, c_addr, c_web, c_din, ack_after);
        model_apply(1'b0, 32'h3000_0080, 32'h0, 4'hF, elat, erdat);
        chk("wrap_status", status_o, 32'h0001_0000);
        chk("wrap_rdat", rdat, 32'hCAFE_F00D);

        // random traffic against the model
        for (int n = 0; n < 80; n++) begin
            logic        we;
            logic [31:0] adr, dat;
            logic [3:0]  sel;
            we  = 1'($urandom);
            dat = $urandom;
            sel = 4'($urandom);
            if ($urandom_range(0, 7) == 0) adr = $urandom;
            else adr = BASE + 32'($urandom_range(0, (4 << AW) - 1));
            xact(we, adr, dat, sel, lat, ncsb, rdat, c_wmask, c_addr, c_web, c_din, ack_after);
            model_apply(we, adr, dat, sel, elat, erdat);
            chk($sformatf("rnd%0d_lat", n), lat, elat);
            chk($sformatf("rnd%0d_csb_cycles", n), ncsb, is_hit(adr) ? 1 : 0);
            chk($sformatf("rnd%0d_status", n), status_o, {m_wr, m_rd});
            if (!we) chk($sformatf("rnd%0d_rdat", n), rdat, erdat);
            if (is_hit(adr)) begin
                chk($sformatf("rnd%0d_addr", n), {24'd0, c_addr}, {24'd0, adr[AW+1:2]});
                chk($sformatf("rnd%0d_wmask", n), {28'd0, c_wmask}, {28'd0, sel});
                if (we) chk($sformatf("rnd%0d_din", n), c_din, dat);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
